// File: rtl/multi_flop_sync_filter_if.sv
// Bundle for the multi-channel synchronizer/glitch filter.
// master drives async_data; slave returns the filtered level and edge pulses.
interface multi_flop_sync_filter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] async_data;
  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             any_change;

  modport master (
    output async_data,
    input  sync_data,
    input  rise_pulse,
    input  fall_pulse,
    input  any_change
  );

  modport slave (
    input  async_data,
    output sync_data,
    output rise_pulse,
    output fall_pulse,
    output any_change
  );
endinterface

// File: rtl/multi_flop_sync_filter.sv
// Per-channel flop-chain synchronizer followed by a persistence filter.
// Ports: dst_clk, rst (sync, active-high), bus (slave: async in; level/pulses out).
module multi_flop_sync_filter #(
  parameter int              WIDTH      = 4,
  parameter int              STAGES     = 2,
  parameter int              FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                     dst_clk,
  input  logic                     rst,
  multi_flop_sync_filter_if.slave  bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LIM = CW'(FILTER_LEN - 1);

  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0][CW-1:0]     cnt;
  logic [WIDTH-1:0][CW-1:0]     cnt_nxt;
  logic [WIDTH-1:0]             accept;
  logic [WIDTH-1:0]             level;
  logic [WIDTH-1:0]             rise;
  logic [WIDTH-1:0]             fall;
  logic                         chg;

  assign s = chain[STAGES-1];

  // Count consecutive cycles the synchronized level disagrees with the
  // accepted level; the count restarts whenever they agree again.
  always_comb begin
    accept  = '0;
    cnt_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != level[i]) begin
        if (cnt[i] == LIM) begin
          accept[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge dst_clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      cnt   <= '0;
      level <= RST_VAL;
      rise  <= '0;
      fall  <= '0;
      chg   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], bus.async_data};
      cnt   <= cnt_nxt;
      level <= level ^ accept;
      // s holds the new level on an accept, so it selects the edge type
      rise  <= accept & s;
      fall  <= accept & ~s;
      chg   <= |accept;
    end
  end

  assign bus.sync_data  = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.any_change = chg;

endmodule

// File: doc/multi_flop_sync_filter.md
MULTI_FLOP_SYNC_FILTER -- requirements
Module: multi_flop_sync_filter

Interface
REQ-001 Parameter WIDTH, default 4, number of independent 1-bit channels, legal range 1..32.
REQ-002 Parameter STAGES, default 2, synchronizer flops per channel, legal range 2..4.
REQ-003 Parameter FILTER_LEN, default 4, consecutive cycles a new synchronized level must persist before acceptance, legal range 1..255; 1 = no filtering.
REQ-004 Parameter RST_VAL, default all-zero, WIDTH-bit reset level of every chain flop and of sync_data.
REQ-005 dst_clk  input  1  destination clock; the only clock; all flops rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 async_data  input  WIDTH  asynchronous inputs, no timing relation to dst_clk.
REQ-008 sync_data  output  WIDTH  synchronized, filtered level per channel, registered.
REQ-009 rise_pulse  output  WIDTH  one-cycle pulse per channel on accepted 0->1 change, registered.
REQ-010 fall_pulse  output  WIDTH  one-cycle pulse per channel on accepted 1->0 change, registered.
REQ-011 any_change  output  1  registered OR of all rise_pulse and fall_pulse bits.

Function
REQ-012 Each channel SHALL pass async_data[i] through a STAGES-deep flop chain; last-stage output is s[i]; no logic between chain flops.
REQ-013 Each channel SHALL own a filter counter of width clog2(FILTER_LEN+1) bits.
REQ-014 When s[i] == sync_data[i], counter SHALL clear to 0 that cycle.
REQ-015 When s[i] != sync_data[i] and counter < FILTER_LEN-1, counter SHALL increment by 1.
REQ-016 When s[i] != sync_data[i] and counter == FILTER_LEN-1, sync_data[i] SHALL load s[i] and counter SHALL clear to 0 (accept event).
REQ-017 Counter SHALL never exceed FILTER_LEN-1; no wrap-around possible.
REQ-018 A level on s[i] differing from sync_data[i] for fewer than FILTER_LEN consecutive cycles SHALL produce no change on sync_data[i] and no pulse.
REQ-019 Latency: input stable before edge E SHALL appear on sync_data at edge E+STAGES+FILTER_LEN-1 (STAGES+FILTER_LEN edges total, counting E).
REQ-020 On an accept event, rise_pulse[i] (new value 1) or fall_pulse[i] (new value 0) SHALL be high for exactly the one cycle in which sync_data[i] first shows the new value.
REQ-021 rise_pulse[i] and fall_pulse[i] SHALL never be high together.
REQ-022 any_change SHALL be high in exactly the cycles where any pulse bit is high.
REQ-023 Channels SHALL be fully independent; simultaneous accept events on several channels SHALL each pulse in the same cycle.
REQ-024 No cross-channel coherency guaranteed; multi-bit values must be Gray-coded or quasi-static at the source (documented user constraint, not checked).
REQ-025 Input toggling every cycle with FILTER_LEN >= 2 SHALL hold sync_data at its current value indefinitely.

Reset
REQ-026 While rst is high at a dst_clk edge: all chain flops and sync_data SHALL load RST_VAL; counters 0; rise_pulse, fall_pulse, any_change 0.
REQ-027 Reset asserted mid-filter SHALL discard partial counts; no pulse SHALL be generated for the discarded transition.
REQ-028 First cycle after rst deasserts: all pulse outputs SHALL be 0 regardless of async_data.
REQ-029 After reset, an input held != RST_VAL SHALL be accepted via normal latency (REQ-019) with a normal pulse.

Verification
REQ-030 WIDTH=4, STAGES=2, FILTER_LEN=4, RST_VAL=0; async_data[0] 0->1 held -> sync_data[0]=1 exactly 6 edges later, rise_pulse[0] and any_change high for 1 cycle.
REQ-031 Same config; async_data[1] high for 3 cycles then low -> sync_data[1] stays 0, no pulses; high for 4 cycles -> accepted, rise then later fall pulse.
REQ-032 Same config; async_data 4'b0000 -> 4'b1111 in one cycle -> all sync_data bits change same cycle, rise_pulse=4'b1111, any_change single 1-cycle pulse.
REQ-033 Same config; async_data[2] 0->1, rst pulsed high 1 cycle after 2 filter counts -> sync_data[2]=0, no pulse, then accepted 6 edges after rst release.
REQ-034 STAGES=3, FILTER_LEN=1, RST_VAL=4'b1010; rst released with async_data=4'b1010 -> no pulses; async_data[0] 0->1 -> sync_data[0]=1 after 4 edges.
REQ-035 FILTER_LEN=4; async_data[3] toggles every cycle for 100 cycles -> sync_data[3] constant, zero pulses, counter never > 3.
